// File: rtl/instr_fetch_decode_pkg.sv
// Shared definitions for the instruction fetch/decode block: word field
// positions, special opcodes, the decoded-operation record and FSM states.
package instr_fetch_decode_pkg;

   localparam int WORD_W  = 24;
   localparam int CODE_HI = 23;
   localparam int CODE_LO = 20;
   localparam int MODE_HI = 19;
   localparam int MODE_LO = 16;
   localparam int A_HI    = 15;
   localparam int A_LO    = 8;
   localparam int B_HI    = 7;
   localparam int B_LO    = 0;

   localparam logic [3:0] OP_HALT   = 4'hF;
   localparam logic [3:0] OP_ILL_LO = 4'hC;
   localparam logic [3:0] OP_ILL_HI = 4'hE;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_PRESENT = 3'd3,
      ST_HALT    = 3'd4
   } state_e;

   typedef struct packed {
      logic [3:0] code;
      logic [3:0] mode;
      logic [7:0] a;
      logic [7:0] b;
      logic       illegal;
   } op_fields_t;

   function automatic logic is_illegal_code(input logic [3:0] code);
      return (code >= OP_ILL_LO) && (code <= OP_ILL_HI);
   endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Purely combinational split of a 24-bit instruction word into its fields,
// with detection of the reserved (illegal) opcode range and of HALT.
module instr_field_decode
   import instr_fetch_decode_pkg::*;
(
   input  logic [WORD_W-1:0] word,
   output op_fields_t        fields,
   output logic              is_halt
);

   always_comb begin
      fields.code    = word[CODE_HI:CODE_LO];
      fields.mode    = word[MODE_HI:MODE_LO];
      fields.a       = word[A_HI:A_LO];
      fields.b       = word[B_HI:B_LO];
      fields.illegal = is_illegal_code(word[CODE_HI:CODE_LO]);
      is_halt        = (word[CODE_HI:CODE_LO] == OP_HALT);
   end

endmodule

// File: rtl/instr_fetch_decode.sv
// Pops instruction words from a fixed-latency stack, decodes them and hands
// them to the ALU over a valid/ready handshake; stops for good on HALT.
module instr_fetch_decode
   import instr_fetch_decode_pkg::*;
#(
   parameter int unsigned POP_LATENCY = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_avail,
   input  logic [23:0] stack_data,
   output logic        stack_pop,
   output logic        op_valid,
   input  logic        op_ready,
   output logic [3:0]  op_code,
   output logic [3:0]  op_mode,
   output logic [7:0]  op_a,
   output logic [7:0]  op_b,
   output logic        op_illegal,
   output logic        halted,
   output logic [7:0]  retired
);

   localparam logic [2:0] WAIT_LOAD = 3'(POP_LATENCY - 1);

   state_e     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       stack_pop_q, stack_pop_d;
   logic       op_valid_q, op_valid_d;
   op_fields_t fields_q, fields_d;
   logic       halted_q, halted_d;
   logic [7:0] retired_q, retired_d;

   op_fields_t dec_fields;
   logic       dec_halt;
   logic       capture;

   instr_field_decode u_decode (
      .word    (stack_data),
      .fields  (dec_fields),
      .is_halt (dec_halt)
   );

   // stack_pop is registered, so it is raised on the edge that enters ISSUE
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      stack_pop_d = 1'b0;
      op_valid_d  = op_valid_q;
      fields_d    = fields_q;
      halted_d    = halted_q;
      retired_d   = retired_q;
      capture     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (instr_avail) begin
               state_d     = ST_ISSUE;
               stack_pop_d = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (POP_LATENCY == 1) begin
               capture = 1'b1;
            end else begin
               state_d = ST_WAIT;
               cnt_d   = WAIT_LOAD;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 3'd0) begin
               capture = 1'b1;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         ST_PRESENT: begin
            if (op_ready) begin
               op_valid_d = 1'b0;
               retired_d  = retired_q + 8'd1;
               if (instr_avail) begin
                  state_d     = ST_ISSUE;
                  stack_pop_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A HALT word is swallowed here and never reaches the ALU
      if (capture) begin
         if (dec_halt) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
         end else begin
            state_d    = ST_PRESENT;
            op_valid_d = 1'b1;
            fields_d   = dec_fields;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 3'd0;
         stack_pop_q <= 1'b0;
         op_valid_q  <= 1'b0;
         fields_q    <= '0;
         halted_q    <= 1'b0;
         retired_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stack_pop_q <= stack_pop_d;
         op_valid_q  <= op_valid_d;
         fields_q    <= fields_d;
         halted_q    <= halted_d;
         retired_q   <= retired_d;
      end
   end

   assign stack_pop  = stack_pop_q;
   assign op_valid   = op_valid_q;
   assign op_code    = fields_q.code;
   assign op_mode    = fields_q.mode;
   assign op_a       = fields_q.a;
   assign op_b       = fields_q.b;
   assign op_illegal = fields_q.illegal;
   assign halted     = halted_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode: an event-level model of the
// fetch/present protocol checked every cycle, plus directed literal checks.
module tb_instr_fetch_decode;

   localparam int          L    = 3;
   localparam logic [23:0] JUNK = 24'h5A5A5A;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        instr_avail = 1'b0;
   logic        op_ready = 1'b0;
   logic [23:0] stack_data = JUNK;
   logic        stack_pop, op_valid, op_illegal, halted;
   logic [3:0]  op_code, op_mode;
   logic [7:0]  op_a, op_b, retired;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   logic [23:0] prog[$];
   logic [23:0] sched[int];

   bit          m_on = 1'b0;
   bit          m_pop, m_valid, m_inflight, m_halted, m_idle, m_next_pop;
   int          m_cap_cycle;
   logic [23:0] m_word;
   logic [7:0]  m_retired;

   int          hs, first_hs, last_hs, budget;
   logic [7:0]  iv;

   instr_fetch_decode #(.POP_LATENCY(L)) dut (
      .clk         (clk),
      .reset       (reset),
      .instr_avail (instr_avail),
      .stack_data  (stack_data),
      .stack_pop   (stack_pop),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .op_code     (op_code),
      .op_mode     (op_mode),
      .op_a        (op_a),
      .op_b        (op_b),
      .op_illegal  (op_illegal),
      .halted      (halted),
      .retired     (retired)
   );

   always #5 clk = ~clk;

   // The stack answers each pop with its next word exactly L cycles later
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      stack_data = sched.exists(cyc) ? sched[cyc] : JUNK;
   end

   always @(negedge clk) begin
      if (stack_pop === 1'b1) begin
         if (prog.size() > 0) sched[cyc + L] = prog.pop_front();
         else sched[cyc + L] = JUNK;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h cycle=%0d", name, actual, expected, cyc);
      end
   endtask

   task automatic checkFields(input string name, input logic [3:0] c, input logic [3:0] m,
                              input logic [7:0] a, input logic [7:0] b, input logic ill);
      checkOutput({name, "_code"}, op_code, c);
      checkOutput({name, "_mode"}, op_mode, m);
      checkOutput({name, "_a"}, op_a, a);
      checkOutput({name, "_b"}, op_b, b);
      checkOutput({name, "_illegal"}, op_illegal, ill);
   endtask

   // Drive one cycle's inputs just after the edge, then wait to sample outputs
   task automatic applyStimulus(input logic rst, input logic avail, input logic rdy);
      @(posedge clk);
      #1;
      reset       = rst;
      instr_avail = avail;
      op_ready    = rdy;
      @(negedge clk);
   endtask

   // Protocol model: a pop is due the cycle after an idle cycle with work
   // available or after a handshake with work available; the word arrives
   // L cycles after the pop and is shown the cycle after that unless HALT.
   always @(negedge clk) begin
      if (m_on) begin
         checkOutput("model_stack_pop", stack_pop, m_pop);
         checkOutput("model_op_valid", op_valid, m_valid);
         checkOutput("model_halted", halted, m_halted);
         checkOutput("model_retired", retired, m_retired);
         if (m_valid) begin
            checkOutput("model_op_code", op_code, m_word[23:20]);
            checkOutput("model_op_mode", op_mode, m_word[19:16]);
            checkOutput("model_op_a", op_a, m_word[15:8]);
            checkOutput("model_op_b", op_b, m_word[7:0]);
            checkOutput("model_op_illegal", op_illegal,
                        (m_word[23:20] >= 4'hC) && (m_word[23:20] <= 4'hE));
         end
      end
      if (reset === 1'b1) begin
         m_pop      = 1'b0;
         m_valid    = 1'b0;
         m_inflight = 1'b0;
         m_halted   = 1'b0;
         m_retired  = 8'd0;
         m_on       = 1'b1;
      end else if (m_on && !m_halted) begin
         m_idle     = !m_pop && !m_inflight && !m_valid;
         m_next_pop = 1'b0;
         if (m_valid && op_ready) begin
            m_valid    = 1'b0;
            m_retired  = m_retired + 8'd1;
            m_next_pop = instr_avail;
         end else if (m_idle && instr_avail) begin
            m_next_pop = 1'b1;
         end
         if (m_pop) begin
            m_inflight  = 1'b1;
            m_cap_cycle = cyc + L;
         end
         if (m_inflight && cyc == m_cap_cycle) begin
            m_inflight = 1'b0;
            if (stack_data[23:20] == 4'hF) begin
               m_halted = 1'b1;
            end else begin
               m_valid = 1'b1;
               m_word  = stack_data;
            end
         end
         m_pop = m_next_pop;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("reset_stack_pop", stack_pop, 0);
      checkOutput("reset_op_valid", op_valid, 0);
      checkOutput("reset_halted", halted, 0);
      checkOutput("reset_retired", retired, 0);
      checkFields("reset", 4'h0, 4'h0, 8'h00, 8'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Basic fetch
      prog.push_back(24'h1A0305);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("basic_pop_c0", stack_pop, 0);
      for (int k = 1; k <= 6; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         checkOutput("basic_pop", stack_pop, k == 1);
         checkOutput("basic_valid", op_valid, k == 5);
         if (k == 5) checkFields("basic", 4'h1, 4'hA, 8'h03, 8'h05, 1'b0);
         if (k == 6) checkOutput("basic_retired", retired, 1);
      end

      // Backpressure followed by an illegal opcode
      prog.push_back(24'h2B1122);
      prog.push_back(24'hD00000);
      applyStimulus(1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 21; k++) begin
         applyStimulus(1'b0, k <= 15, k >= 15);
         checkOutput("bp_pop", stack_pop, (k == 1) || (k == 16));
         checkOutput("bp_valid", op_valid, ((k >= 5) && (k <= 15)) || (k == 20));
         if (k >= 5 && k <= 15) checkFields("bp_hold", 4'h2, 4'hB, 8'h11, 8'h22, 1'b0);
         if (k == 20) checkFields("illegal", 4'hD, 4'h0, 8'h00, 8'h00, 1'b1);
         if (k == 21) checkOutput("illegal_retired", retired, 3);
      end

      // HALT with work still available
      prog.push_back(24'hF00000);
      applyStimulus(1'b0, 1'b1, 1'b1);
      for (int k = 1; k <= 20; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b1);
         checkOutput("halt_pop", stack_pop, k == 1);
         checkOutput("halt_valid", op_valid, 0);
         checkOutput("halt_halted", halted, k >= 5);
         checkOutput("halt_retired", retired, 3);
      end

      // Reset out of HALT, then reset in the middle of a pop wait
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("unhalt_halted", halted, 0);
      checkOutput("unhalt_retired", retired, 0);
      checkFields("unhalt", 4'h0, 4'h0, 8'h00, 8'h00, 1'b0);
      prog.push_back(24'h123456);
      applyStimulus(1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(k == 3, 1'b0, 1'b1);
         checkOutput("midwait_pop", stack_pop, k == 1);
         checkOutput("midwait_valid", op_valid, 0);
         if (k == 4) checkFields("midwait", 4'h0, 4'h0, 8'h00, 8'h00, 1'b0);
      end

      // 256 back-to-back handshakes wrap the retired counter
      for (int i = 0; i < 257; i++) begin
         iv = 8'(i);
         prog.push_back({4'(i % 15), iv[3:0], iv, ~iv});
      end
      hs = 0; first_hs = 0; last_hs = 0; budget = 0;
      while (hs < 256 && budget < 2000) begin
         applyStimulus(1'b0, 1'b1, 1'b1);
         budget++;
         if (op_valid === 1'b1) begin
            hs++;
            if (hs == 1) first_hs = cyc;
            if (hs == 256) last_hs = cyc;
         end
      end
      checkOutput("wrap_handshakes", hs, 256);
      checkOutput("wrap_period", last_hs - first_hs, 255 * (L + 2));
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("wrap_retired", retired, 0);
      checkOutput("wrap_backtoback_pop", stack_pop, 1);
      for (int k = 0; k < 7; k++) applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("post_wrap_retired", retired, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
